w0rm_core_mem_stage: RTL and testbench

Memory/writeback stage directly downstream of the core ALU. Consumes the ALU result plus the sideband that travelled through the ALU user-data channel. It either forwards the result to register writeback, or uses the result as an address for a single load or store on the data bus. It throttles the ALU through `mem_ready`, which the ALU folds into its own `alu_ready`.

---
 rtl/w0rm_core_pkg.sv | 37 +++
 rtl/w0rm_core_mem_stage.sv | 160 ++++++++++++++++
 tb/tb_w0rm_core_mem_stage.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/w0rm_core_pkg.sv
// ---------------------------------------------------------------------------
// w0rm_core_pkg
// Shared definitions for the w0rm core pipeline:
//   - memory-op codes carried from decode through the ALU to the mem stage
//   - mem-stage FSM state encoding
//   - layout of the ALU user-data channel {mem_op, dest_reg, store_data}
// ---------------------------------------------------------------------------
package w0rm_core_pkg;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'b00,
        MEM_OP_LOAD  = 2'b01,
        MEM_OP_STORE = 2'b10,
        MEM_OP_RSVD  = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_BUS_REQ  = 2'b01,
        ST_BUS_WAIT = 2'b10
    } mem_state_e;

    // Default core widths; the user-data channel is sized from these.
    localparam int CORE_DATA_WIDTH     = 8;
    localparam int CORE_REG_ADDR_WIDTH = 4;

    // Sideband packed into the ALU USER_WIDTH channel. Field order is MSB
    // first, so store_data occupies the low bits and mem_op the top two.
    typedef struct packed {
        mem_op_e                          mem_op;
        logic [CORE_REG_ADDR_WIDTH-1:0]   dest_reg;
        logic [CORE_DATA_WIDTH-1:0]       store_data;
    } alu_user_t;

    localparam int ALU_USER_WIDTH = $bits(alu_user_t);

endpackage

// File: rtl/w0rm_core_mem_stage.sv
// ---------------------------------------------------------------------------
// w0rm_core_mem_stage
// Memory/writeback stage behind the core ALU. A NONE op is written back the
// cycle after acceptance; LOAD/STORE use the ALU result as the bus address
// for a single bus access. Throttles the ALU through mem_ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous pipeline flush
//   in_valid/in_result/in_mem_op/in_dest_reg/in_store_data
//                       ALU result and its sideband
//   mem_ready           stage can accept this cycle (state is IDLE)
//   bus_valid/bus_we/bus_addr/bus_wdata, bus_ready
//                       request channel, held stable until bus_ready
//   bus_rdata/bus_rdata_valid
//                       load response, only looked at while waiting for it
//   wb_valid/wb_reg/wb_data
//                       one-cycle register-file write strobe
// ---------------------------------------------------------------------------
module w0rm_core_mem_stage
    import w0rm_core_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic [1:0]                in_mem_op,
    input  logic [REG_ADDR_WIDTH-1:0] in_dest_reg,
    input  logic [DATA_WIDTH-1:0]     in_store_data,
    output logic                      mem_ready,
    output logic                      bus_valid,
    output logic                      bus_we,
    output logic [DATA_WIDTH-1:0]     bus_addr,
    output logic [DATA_WIDTH-1:0]     bus_wdata,
    input  logic                      bus_ready,
    input  logic [DATA_WIDTH-1:0]     bus_rdata,
    input  logic                      bus_rdata_valid,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_reg,
    output logic [DATA_WIDTH-1:0]     wb_data
);

    mem_state_e                state_q;
    logic                      kill_q;
    logic [REG_ADDR_WIDTH-1:0] dest_q;
    logic                      bus_valid_q;
    logic                      bus_we_q;
    logic [DATA_WIDTH-1:0]     bus_addr_q;
    logic [DATA_WIDTH-1:0]     bus_wdata_q;
    logic                      wb_valid_q;
    logic [REG_ADDR_WIDTH-1:0] wb_reg_q;
    logic [DATA_WIDTH-1:0]     wb_data_q;

    mem_op_e in_op;
    logic    accept;

    assign in_op = mem_op_e'(in_mem_op);

    // mem_ready depends on state only, so there is no combinational path
    // from in_valid back into the ALU's ready.
    assign mem_ready = (state_q == ST_IDLE);
    assign accept    = in_valid && mem_ready && !flush;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, whatever order the statements appear in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            kill_q      <= 1'b0;
            dest_q      <= '0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
        end else begin
            // Writeback is a strobe: it only survives a cycle when re-set.
            wb_valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    kill_q <= 1'b0;
                    if (accept) begin
                        case (in_op)
                            MEM_OP_NONE: begin
                                wb_valid_q <= 1'b1;
                                wb_data_q  <= in_result;
                                wb_reg_q   <= in_dest_reg;
                            end
                            MEM_OP_LOAD: begin
                                state_q     <= ST_BUS_REQ;
                                bus_valid_q <= 1'b1;
                                bus_we_q    <= 1'b0;
                                bus_addr_q  <= in_result;
                                dest_q      <= in_dest_reg;
                            end
                            MEM_OP_STORE: begin
                                state_q     <= ST_BUS_REQ;
                                bus_valid_q <= 1'b1;
                                bus_we_q    <= 1'b1;
                                bus_addr_q  <= in_result;
                                bus_wdata_q <= in_store_data;
                            end
                            default: ; // reserved op: consumed and dropped
                        endcase
                    end
                end

                ST_BUS_REQ: begin
                    if (bus_ready) begin
                        bus_valid_q <= 1'b0;
                        state_q     <= bus_we_q ? ST_IDLE : ST_BUS_WAIT;
                    end
                    // A store has nothing to suppress; a load carries the
                    // flush forward so its eventual writeback is dropped.
                    if (bus_ready && bus_we_q) begin
                        kill_q <= 1'b0;
                    end else if (flush) begin
                        kill_q <= 1'b1;
                    end
                end

                ST_BUS_WAIT: begin
                    if (bus_rdata_valid) begin
                        wb_valid_q <= !(kill_q || flush);
                        if (!(kill_q || flush)) begin
                            wb_data_q <= bus_rdata;
                            wb_reg_q  <= dest_q;
                        end
                        kill_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (flush) begin
                        kill_q <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    bus_valid_q <= 1'b0;
                    kill_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_reg    = wb_reg_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_w0rm_core_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_w0rm_core_mem_stage
// Directed bench for the memory/writeback stage. A transaction-level model
// tracks the one outstanding bus operation and the expected writeback; a
// compare process checks the DUT against it on every falling edge, and the
// stimulus sequence pins the model with hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_w0rm_core_mem_stage;
    import w0rm_core_pkg::*;

    localparam int DW = 8;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_result;
    logic [1:0]    in_mem_op;
    logic [RW-1:0] in_dest_reg;
    logic [DW-1:0] in_store_data;
    logic          mem_ready;
    logic          bus_valid;
    logic          bus_we;
    logic [DW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ready;
    logic [DW-1:0] bus_rdata;
    logic          bus_rdata_valid;
    logic          wb_valid;
    logic [RW-1:0] wb_reg;
    logic [DW-1:0] wb_data;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    w0rm_core_mem_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_result       (in_result),
        .in_mem_op       (in_mem_op),
        .in_dest_reg     (in_dest_reg),
        .in_store_data   (in_store_data),
        .mem_ready       (mem_ready),
        .bus_valid       (bus_valid),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_ready       (bus_ready),
        .bus_rdata       (bus_rdata),
        .bus_rdata_valid (bus_rdata_valid),
        .wb_valid        (wb_valid),
        .wb_reg          (wb_reg),
        .wb_data         (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: at most one bus operation in flight. It is "requesting" until
    // the bus accepts it, then (loads only) "awaiting data". A flush any
    // time after acceptance marks it killed, which only matters for loads.
    // ------------------------------------------------------------------
    typedef struct {
        bit            active;
        bit            is_store;
        bit            granted;
        bit            killed;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [RW-1:0] dest;
    } pend_t;

    pend_t         m_pend;
    bit            m_wb_valid;
    logic [RW-1:0] m_wb_reg;
    logic [DW-1:0] m_wb_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend     <= '{default: '0};
            m_wb_valid <= 1'b0;
            m_wb_reg   <= '0;
            m_wb_data  <= '0;
        end else begin
            pend_t p;
            bit    wv;
            p  = m_pend;
            wv = 1'b0;
            if (!p.active) begin
                if (in_valid && !flush) begin
                    if (in_mem_op == MEM_OP_NONE) begin
                        wv = 1'b1;
                        m_wb_reg  <= in_dest_reg;
                        m_wb_data <= in_result;
                    end else if (in_mem_op != MEM_OP_RSVD) begin
                        p = '{active: 1'b1, is_store: (in_mem_op == MEM_OP_STORE),
                              granted: 1'b0, killed: 1'b0, addr: in_result,
                              wdata: in_store_data, dest: in_dest_reg};
                    end
                end
            end else begin
                if (flush) p.killed = 1'b1;
                if (!p.granted) begin
                    if (bus_ready) begin
                        if (p.is_store) p.active = 1'b0;
                        else p.granted = 1'b1;
                    end
                end else if (bus_rdata_valid) begin
                    if (!p.killed) begin
                        wv = 1'b1;
                        m_wb_reg  <= p.dest;
                        m_wb_data <= bus_rdata;
                    end
                    p.active = 1'b0;
                end
            end
            m_pend     <= p;
            m_wb_valid <= wv;
        end
    end

    // Compare process: every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n && check_en) begin
            check("mem_ready", mem_ready, !m_pend.active);
            check("bus_valid", bus_valid, m_pend.active && !m_pend.granted);
            check("wb_valid", wb_valid, m_wb_valid);
            if (m_pend.active && !m_pend.granted) begin
                check("bus_addr", bus_addr, m_pend.addr);
                check("bus_we", bus_we, m_pend.is_store);
                if (m_pend.is_store) check("bus_wdata", bus_wdata, m_pend.wdata);
            end
            if (m_wb_valid) begin
                check("wb_reg", wb_reg, m_wb_reg);
                check("wb_data", wb_data, m_wb_data);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [DW-1:0] res,
                          input logic [RW-1:0] dest, input logic [DW-1:0] sd);
        in_valid      = 1'b1;
        in_mem_op     = op;
        in_result     = res;
        in_dest_reg   = dest;
        in_store_data = sd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_result = '0;
        in_mem_op = MEM_OP_NONE;
        in_dest_reg = '0;
        in_store_data = '0;
        bus_ready = 1'b0;
        bus_rdata = '0;
        bus_rdata_valid = 1'b0;

        // Reset values
        step();
        step();
        check("rst mem_ready", mem_ready, 1);
        check("rst bus_valid", bus_valid, 0);
        check("rst bus_we", bus_we, 0);
        check("rst bus_addr", bus_addr, 0);
        check("rst bus_wdata", bus_wdata, 0);
        check("rst wb_valid", wb_valid, 0);
        check("rst wb_reg", wb_reg, 0);
        check("rst wb_data", wb_data, 0);
        rst_n = 1'b1;
        check_en = 1'b1;
        step();

        // Three back-to-back NONE ops
        set_op(MEM_OP_NONE, 8'h11, 4'd1, 8'h00);
        step();
        check("none1 wb", {wb_valid, wb_reg, wb_data}, {1'b1, 4'd1, 8'h11});
        set_op(MEM_OP_NONE, 8'h22, 4'd2, 8'h00);
        step();
        check("none2 wb", {wb_valid, wb_reg, wb_data}, {1'b1, 4'd2, 8'h22});
        set_op(MEM_OP_NONE, 8'h33, 4'd3, 8'h00);
        step();
        check("none3 wb", {wb_valid, wb_reg, wb_data}, {1'b1, 4'd3, 8'h33});
        check("none3 mem_ready", mem_ready, 1);
        in_valid = 1'b0;
        step();
        check("none idle wb", wb_valid, 0);

        // LOAD 0x40 -> r5, two bus stall cycles, data 0xA5
        set_op(MEM_OP_LOAD, 8'h40, 4'd5, 8'h00);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("load req addr", {bus_valid, bus_we, bus_addr}, {1'b1, 1'b0, 8'h40});
            check("load req ready", mem_ready, 0);
            step();
        end
        check("load req addr", {bus_valid, bus_addr}, {1'b1, 8'h40});
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        check("load wait", {bus_valid, mem_ready, wb_valid}, 3'b000);
        bus_rdata_valid = 1'b1;
        bus_rdata = 8'hA5;
        step();
        bus_rdata_valid = 1'b0;
        check("load wb", {wb_valid, wb_reg, wb_data}, {1'b1, 4'd5, 8'hA5});
        check("load done ready", mem_ready, 1);
        step();

        // STORE 0x5A to 0x80, bus accepts immediately
        set_op(MEM_OP_STORE, 8'h80, 4'd0, 8'h5A);
        bus_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("store req", {bus_valid, bus_we, bus_addr, bus_wdata}, {1'b1, 1'b1, 8'h80, 8'h5A});
        check("store ready low", mem_ready, 0);
        step();
        bus_ready = 1'b0;
        check("store done", {mem_ready, bus_valid, wb_valid}, 3'b100);
        step();

        // LOAD killed by flush while waiting for data
        set_op(MEM_OP_LOAD, 8'h30, 4'd7, 8'h00);
        step();
        in_valid = 1'b0;
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("kill still busy", mem_ready, 0);
        step();
        bus_rdata_valid = 1'b1;
        bus_rdata = 8'hFF;
        step();
        bus_rdata_valid = 1'b0;
        check("kill no wb", {wb_valid, mem_ready}, 2'b01);
        set_op(MEM_OP_NONE, 8'h77, 4'd9, 8'h00);
        step();
        in_valid = 1'b0;
        check("post-kill wb", {wb_valid, wb_reg, wb_data}, {1'b1, 4'd9, 8'h77});

        // Spurious rdata in IDLE, reserved op, flush in IDLE
        bus_rdata_valid = 1'b1;
        bus_rdata = 8'hEE;
        step();
        bus_rdata_valid = 1'b0;
        check("spurious rdata", {wb_valid, bus_valid}, 2'b00);
        set_op(MEM_OP_RSVD, 8'h12, 4'd3, 8'h34);
        step();
        in_valid = 1'b0;
        check("rsvd op", {wb_valid, bus_valid, mem_ready}, 3'b001);
        set_op(MEM_OP_NONE, 8'h44, 4'd6, 8'h00);
        step();
        check("pre-flush wb", {wb_valid, wb_data}, {1'b1, 8'h44});
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush idle wb", wb_valid, 0);
        step();

        // Async reset during BUS_REQ
        set_op(MEM_OP_LOAD, 8'h55, 4'd4, 8'h00);
        step();
        in_valid = 1'b0;
        check("rst-mid req", bus_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async bus_valid", bus_valid, 0);
        check("async mem_ready", mem_ready, 1);
        step();
        rst_n = 1'b1;
        step();
        check("post-rst", {mem_ready, bus_valid, wb_valid}, 3'b100);
        set_op(MEM_OP_NONE, 8'h66, 4'd2, 8'h00);
        step();
        in_valid = 1'b0;
        check("post-rst wb", {wb_valid, wb_reg, wb_data}, {1'b1, 4'd2, 8'h66});
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
